mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide engine that produces the HI/LO results consumed by decode.
- Sits in EX alongside the ALU, executes MULT/MULTU/DIV/DIVU/MTHI/MTLO, and drives the 64-bit result that the pipeline carries to write-back and the HI/LO file.
- Radix-2, one bit per cycle. A busy/done handshake lets the hazard logic stall MFHI/MFLO and back-to-back mult/div ops.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  operation request; sampled only in IDLE.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  input  32  rt operand (divisor / multiplier).
- flush  input  1  synchronous cancel from exception/eret logic.
- busy  output  1  high while an iterative op is in flight.
- done  output  1  one-cycle pulse when hi/lo have been updated.
- hi  output  32  HI register.
- lo  output  32  LO register.
- result  output  64  {hi, lo}.

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0. Reset mid-operation abandons the op.
- States: IDLE, CALC, FIX. done is a registered output.
- IDLE, start=1, flush=0, op in 000..011 (edge T):
  - latch |a|, |b| for signed ops, raw values for unsigned ops;
  - latch sign flags; go to CALC with count=0.
  - busy=1 from after edge T through after edge T+32.
- CALC:
  - one iteration per edge.
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring; shift remainder left, trial subtract, set quotient bit.
  - At edge T+32 (count=31) go to FIX.
- FIX (edge T+33):
  - apply sign correction;
  - write hi/lo;
  - go to IDLE;
  - busy=0 and done=1 for exactly the cycle after T+33.
  - Total latency from start to visible result: 34 edges.
- Sign rules:
  - Signed product is negated (64-bit two's complement) when sign(a)≠sign(b).
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops apply no correction.
- Multiply result: hi=product[63:32], lo=product[31:0].
- Divide result: lo=quotient, hi=remainder.
- Divide by zero (b=0, signed or unsigned): still 34 edges; lo=32'hFFFFFFFF, hi=a unmodified.
- Overflow 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0. No trap.
- MTHI/MTLO in IDLE with start=1: at edge T, hi (or lo) is loaded with a; busy stays 0; done=1 for the following cycle.
- op 110/111: ignored. No state change, no done.
- start while busy: ignored. No queueing. The hazard unit must stall.
- flush=1: from any state, returns to IDLE at the next edge; busy=0; hi/lo unchanged; no done. If flush and start are both high in IDLE, flush wins.
- hi/lo change only at FIX or at MTHI/MTLO, never during CALC.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE (-2), b=0x00000003 -> busy for 33 cycles, done pulse at edge 34; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> after 34 edges lo=0xFFFFFFFF, hi=0x12345678. A second start pulsed at edge T+5 -> ignored, single done.
- MTHI a=0xDEADBEEF, then MTLO a=0x0BADF00D on the next cycle -> each gives a 1-cycle done, busy never asserts; result=0xDEADBEEF0BADF00D.
- Start MULT 5×6, flush at edge T+10 -> busy drops after T+10, no done, hi/lo keep prior values. Repeat the op with reset=0 pulsed mid-CALC -> hi=lo=0, busy=0 immediately (asynchronous).

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between EX-stage control and the multiply/divide engine.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 start;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 flush;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic [2*WIDTH-1:0]   result;

    // Pipeline control side: issues ops, observes HI/LO.
    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo, result
    );

    // Engine side.
    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo, result
    );
endinterface

// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide engine holding the HI/LO registers.
// One iteration per cycle; a FIX cycle applies sign correction and writes HI/LO.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(ITER);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;       // multiply: {partial, multiplier}; divide: {rem, quo}
    logic [WIDTH-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;   // original dividend for divide-by-zero
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    // Operand magnitudes and sign flags for the op being requested.
    logic                 op_signed;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_abs, b_abs;

    always_comb begin
        op_signed = ~bus.op[0];
        a_neg     = op_signed & bus.a[WIDTH-1];
        b_neg     = op_signed & bus.b[WIDTH-1];
        a_abs     = a_neg ? (~bus.a + 1'b1) : bus.a;
        b_abs     = b_neg ? (~bus.b + 1'b1) : bus.b;
    end

    // Single-step datapath for both shift-add multiply and restoring divide.
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = rem_sh - {1'b0, opnd_q};
    end

    // Sign-corrected results applied in the FIX cycle.
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Flush beats a same-cycle start.
                if (!bus.flush && bus.start) begin
                    case (bus.op)
                        OpMult, OpMultu, OpDiv, OpDivu: begin
                            state_d    = StCalc;
                            count_d    = '0;
                            is_div_d   = bus.op[1];
                            neg_res_d  = a_neg ^ b_neg;
                            neg_rem_d  = a_neg;
                            div_zero_d = (bus.b == '0);
                            a_raw_d    = bus.a;
                            if (bus.op[1]) begin
                                opnd_d = b_abs;
                                acc_d  = {{WIDTH{1'b0}}, a_abs};
                            end else begin
                                opnd_d = a_abs;
                                acc_d  = {{WIDTH{1'b0}}, b_abs};
                            end
                        end
                        OpMthi: begin
                            hi_d   = bus.a;
                            done_d = 1'b1;
                        end
                        OpMtlo: begin
                            lo_d   = bus.a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[WIDTH]) begin
                            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(ITER - 1)) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (div_zero_q) begin
                        hi_d = a_raw_q;
                        lo_d = {WIDTH{1'b1}};
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset abandons any op in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    // Outputs.
    always_comb begin
        bus.busy   = (state_q != StIdle);
        bus.done   = done_q;
        bus.hi     = hi_q;
        bus.lo     = lo_q;
        bus.result = {hi_q, lo_q};
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, sign rules, corner cases, flush and reset.
module tb_mult_div_unit;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an op at edge T, then follow it until done (bounded at 60 edges).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output int busy_cyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges     = 1;
        busy_cyc  = bus.busy ? 1 : 0;
        while (!bus.done && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.busy) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.result !== 64'h0) begin
            bad++;
            $display("FAIL reset_result got=%h want 0", bus.result);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_mult();
        int edges, busy_cyc;
        issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, edges, busy_cyc);
        total++;
        if (edges !== 34) begin
            bad++;
            $display("FAIL mult_latency got=%0d want 34", edges);
        end
        total++;
        if (busy_cyc !== 33) begin
            bad++;
            $display("FAIL mult_busy_cycles got=%0d want 33", busy_cyc);
        end
        total++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
            bad++;
            $display("FAIL mult_neg got=%h_%h want ffffffff_fffffffa", bus.hi, bus.lo);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL mult_done_pulse done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_multu_divu();
        int edges, busy_cyc;
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, busy_cyc);
        total++;
        if (edges !== 34 || bus.result !== 64'hFFFF_FFFE_0000_0001) begin
            bad++;
            $display("FAIL multu got=%h edges=%0d want fffffffe00000001 34", bus.result, edges);
        end
        issue(3'b011, 32'd100, 32'd7, edges, busy_cyc);
        total++;
        if (edges !== 34 || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            bad++;
            $display("FAIL divu got hi=%0d lo=%0d edges=%0d want 2 14 34", bus.hi, bus.lo, edges);
        end
    endtask

    task automatic test_div_signed();
        int edges, busy_cyc;
        issue(3'b010, 32'hFFFF_FFF9, 32'd2, edges, busy_cyc);
        total++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL div_neg got=%h_%h want ffffffff_fffffffd", bus.hi, bus.lo);
        end
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, edges, busy_cyc);
        total++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
            bad++;
            $display("FAIL div_overflow got=%h_%h want 00000000_80000000", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div_zero();
        int dones, first;
        dones = 0;
        first = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b011;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5) begin
                bus.start = 1'b1;
                bus.b     = 32'd1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (first == 0) first = k + 1;
            end
        end
        total++;
        if (dones !== 1 || first !== 34) begin
            bad++;
            $display("FAIL divzero_done count=%0d at=%0d want 1 34", dones, first);
        end
        total++;
        if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h1234_5678) begin
            bad++;
            $display("FAIL divzero_result got=%h_%h want 12345678_ffffffff", bus.hi, bus.lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.a     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.hi !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL mthi done=%b busy=%b hi=%h want 1 0 deadbeef",
                     bus.done, bus.busy, bus.hi);
        end
        bus.op = 3'b101;
        bus.a  = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.lo !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL mtlo done=%b busy=%b lo=%h want 1 0 0badf00d",
                     bus.done, bus.busy, bus.lo);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b0 || bus.result !== 64'hDEAD_BEEF_0BAD_F00D) begin
            bad++;
            $display("FAIL mthi_mtlo_result done=%b got=%h want 0 deadbeef0badf00d",
                     bus.done, bus.result);
        end
    endtask

    task automatic test_noop();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.op    = (i == 0) ? 3'b110 : 3'b111;
            bus.a     = 32'h1111_1111;
            bus.b     = 32'h2222_2222;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            @(posedge clk);
            #1;
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
                bus.result !== 64'hDEAD_BEEF_0BAD_F00D) begin
                bad++;
                $display("FAIL noop%0d done=%b busy=%b got=%h want 0 0 deadbeef0badf00d",
                         i, bus.done, bus.busy, bus.result);
            end
        end
    endtask

    task automatic test_flush();
        int dones;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) bus.flush = 1'b1;
            @(posedge clk);
            #1;
            bus.flush = 1'b0;
            if (bus.done) dones++;
            if (k == 9) begin
                total++;
                if (bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL flush_pre_busy got=%b want 1", bus.busy);
                end
            end
            if (k == 10) begin
                total++;
                if (bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL flush_busy got=%b want 0", bus.busy);
                end
            end
        end
        total++;
        if (dones !== 0 || bus.result !== 64'hDEAD_BEEF_0BAD_F00D) begin
            bad++;
            $display("FAIL flush_keep dones=%0d got=%h want 0 deadbeef0badf00d",
                     dones, bus.result);
        end
        // Flush and start together in IDLE: flush wins.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 3'b100;
        bus.a     = 32'h0000_0012;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        total++;
        if (bus.done !== 1'b0 || bus.hi !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL flush_wins done=%b hi=%h want 0 deadbeef", bus.done, bus.hi);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.result !== 64'h0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset busy=%b done=%b got=%h want 0 0 0",
                     bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        int edges, busy_cyc;
        issue(3'b000, 32'd5, 32'd6, edges, busy_cyc);
        total++;
        if (edges !== 34 || bus.result !== 64'd30) begin
            bad++;
            $display("FAIL b2b_mult got=%h edges=%0d want 1e 34", bus.result, edges);
        end
        issue(3'b011, 32'd30, 32'd4, edges, busy_cyc);
        total++;
        if (edges !== 34 || bus.lo !== 32'd7 || bus.hi !== 32'd2) begin
            bad++;
            $display("FAIL b2b_divu got hi=%0d lo=%0d edges=%0d want 2 7 34",
                     bus.hi, bus.lo, edges);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        bus.flush = 1'b0;
        test_reset();
        test_mult();
        test_multu_divu();
        test_div_signed();
        test_div_zero();
        test_mthi_mtlo();
        test_noop();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
